fb_write_scheduler: RTL
=======================

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_PIXELS, default hdmi_const::FB_WIDTH*hdmi_const::FB_HEIGHT (57600): number of pixels cleared per clear operation.
REQ-002 The block SHALL have parameter PIX_W, default hdmi_const::FB_SIZE: pixel-index width.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk_in  input  1  single clock, the frame buffer write clock
- rst_in  input  1  synchronous active-high reset
- cpu_valid_in / cpu_ready_out  in/out  1/1  CPU write handshake
- cpu_addr_in  input  PIX_W  CPU pixel index
- cpu_data_in  input  16  CPU pixel, RGB565
- blt_valid_in / blt_ready_out  in/out  1/1  blitter write handshake
- blt_addr_in  input  PIX_W  blitter pixel index
- blt_data_in  input  16  blitter pixel, RGB565
- clear_start_in  input  1  pulse: fill the back buffer
- clear_color_in  input  16  fill colour, sampled on clear_start_in
- clear_busy_out  output  1  clear in progress
- swap_req_in  input  1  pulse: request a buffer swap
- frame_start_in  input  1  pulse, already synchronised to clk_in: display frame boundary
- swap_pending_out  output  1  a swap is requested but not yet done
- swap_done_out  output  1  one-cycle pulse when the swap is issued
- fb_write_data_out  output  16  to frame buffer write_data
- fb_write_addr_out  output  2*PIX_W  to frame buffer write_addr; equals pixel index << 1
- fb_write_enable_out  output  1  to frame buffer write_enable
- fb_swap_buffer_out  output  1  to frame buffer swap_buffer
- write_count_out  output  24  writes issued since the last swap

Function
REQ-004 The FSM SHALL have states IDLE, CLEAR and SWAP_WAIT.
REQ-005 In IDLE, the block SHALL grant at most one requester per cycle, using 2-way round-robin; the last-granted requester loses a tie; the pointer resets to favour CPU.
REQ-006 Ready outputs SHALL be combinational and SHALL be high only for the granted requester in IDLE; a transfer occurs when valid && ready; a requester SHALL hold its valid, addr and data stable until ready.
REQ-007 A transfer in cycle N SHALL appear on the fb_write_*_out signals in cycle N+1 (registered), with fb_write_enable_out high for exactly one cycle.
REQ-008 In IDLE, clear_start_in SHALL latch clear_color_in and move to CLEAR; clear_start_in SHALL take priority over a pending swap and over grants in that cycle.
REQ-009 In CLEAR, the block SHALL write clear_color to pixel indices 0..NUM_PIXELS-1, one per cycle in ascending order.
- Both readys SHALL be low in CLEAR.
- clear_busy_out SHALL be high from the cycle after clear_start_in until the cycle after the last write is issued.
- After index NUM_PIXELS-1, the FSM SHALL return to IDLE.
- clear_start_in SHALL be ignored in CLEAR and in SWAP_WAIT.
REQ-010 swap_req_in in any state SHALL set swap_pending_out; further swap_req_in pulses while pending SHALL be ignored, with no queuing.
REQ-011 In IDLE with swap pending and no clear_start_in, the FSM SHALL enter SWAP_WAIT; both readys SHALL be low in SWAP_WAIT.
REQ-012 In SWAP_WAIT, the first frame_start_in seen SHALL pulse fb_swap_buffer_out and swap_done_out together in the next cycle, clear swap pending, and return to IDLE.
- A frame_start_in coincident with SWAP_WAIT entry SHALL not count.
- frame_start_in in other states SHALL be ignored.
REQ-013 The swap pulse SHALL never coincide with fb_write_enable_out, so all prior writes land in the old back buffer.

Reset
REQ-014 On rst_in, the block SHALL:
- set state to IDLE, swap pending to 0, the RR pointer to CPU, and the clear index to 0;
- drive all outputs to 0, including fb_write_addr_out, fb_write_data_out and write_count_out;
- abort any clear or swap in progress immediately; a reset mid-clear or mid-swap SHALL leave no pulse afterwards.

Configuration
REQ-015 With FB_SCHED_STATS_EN defined, write_count_out SHALL count every fb_write_enable_out cycle (clear writes included), saturate at 2^24-1, and reset to 0 on the cycle fb_swap_buffer_out pulses.
REQ-016 Without FB_SCHED_STATS_EN, write_count_out SHALL be tied to 0 and no counter logic SHALL exist.

Structure
REQ-017 The state enum, requester-id enum and write-count width SHALL live in package fb_sched_pkg; frame dimensions SHALL come from hdmi_const.
REQ-018 The round-robin grant logic SHALL be sub-module fb_rr_arbiter (2 requesters, enable input, one-hot grant, pointer update on grant).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- CPU and blitter both valid for 4 cycles, addrs 10/20 -> grants alternate CPU, BLT, CPU, BLT; writes appear 1 cycle later at addr 20/40.
- clear_start_in with colour 16'hF800, NUM_PIXELS=16 -> 16 consecutive writes at addr 0,2..30 of F800; readys low throughout; busy drops after the last write.
- swap_req_in during a clear, then frame_start_in at clear+5 cycles -> no swap during the clear; SWAP_WAIT entered after the clear; swap and done pulse 1 cycle after the next frame_start_in.
- swap_req_in and frame_start_in in the same IDLE cycle -> no swap; swap occurs only on the following frame_start_in.
- rst_in asserted mid-clear at index 7 -> next cycle all outputs 0, state IDLE, no further clear writes.
- With FB_SCHED_STATS_EN, 5 CPU writes then a swap -> write_count_out=5 before the swap, 0 after.

Source files
------------

// File: rtl/fb_sched_pkg.sv
// fb_sched_pkg: scheduler state, requester ids and write-count width
package fb_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SWAP_WAIT} state_e;
  typedef enum logic {RR_CPU, RR_BLT} rr_id_e;
  localparam int WCNT_W = 24;
endpackage

// File: rtl/hdmi_const.sv
// hdmi_const: frame buffer geometry shared by the display pipeline
package hdmi_const;
  localparam int FB_WIDTH  = 240;
  localparam int FB_HEIGHT = 240;
  localparam int FB_SIZE   = 16;
endpackage

// File: rtl/fb_rr_arbiter.sv
// fb_rr_arbiter: 2-way round-robin, one-hot grant, last-granted requester loses ties
module fb_rr_arbiter
  import fb_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  rr_id_e prio_q, prio_d;
  // serve the favoured requester if it asks, else the other; favour flips to the loser
  always_comb begin
    gnt = '0;
    if (en) gnt = (prio_q == RR_CPU) ? (req[0] ? 2'b01 : {req[1], 1'b0}) : (req[1] ? 2'b10 : {1'b0, req[0]});
    prio_d = gnt[0] ? RR_BLT : gnt[1] ? RR_CPU : prio_q;
  end
  // priority pointer, favours the CPU out of reset
  always_ff @(posedge clk) begin
    if (rst) prio_q <= RR_CPU;
    else prio_q <= prio_d;
  end
endmodule

// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler: merges CPU/blitter writes, clears and vsync-aligned swaps; FB_SCHED_STATS_EN adds a write counter
module fb_write_scheduler
  import fb_sched_pkg::*;
#(
  parameter int NUM_PIXELS = hdmi_const::FB_WIDTH * hdmi_const::FB_HEIGHT,
  parameter int PIX_W      = hdmi_const::FB_SIZE
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               cpu_valid_in,
  output logic               cpu_ready_out,
  input  logic [PIX_W-1:0]   cpu_addr_in,
  input  logic [15:0]        cpu_data_in,
  input  logic               blt_valid_in,
  output logic               blt_ready_out,
  input  logic [PIX_W-1:0]   blt_addr_in,
  input  logic [15:0]        blt_data_in,
  input  logic               clear_start_in,
  input  logic [15:0]        clear_color_in,
  output logic               clear_busy_out,
  input  logic               swap_req_in,
  input  logic               frame_start_in,
  output logic               swap_pending_out,
  output logic               swap_done_out,
  output logic [15:0]        fb_write_data_out,
  output logic [2*PIX_W-1:0] fb_write_addr_out,
  output logic               fb_write_enable_out,
  output logic               fb_swap_buffer_out,
  output logic [WCNT_W-1:0]  write_count_out
);
  state_e state_q, state_d;
  logic pend_q, pend_d, we_q, we_d, swap_q, swap_d, arb_en, last_px;
  logic [PIX_W-1:0] idx_q, idx_d, waddr_q, waddr_d;
  logic [15:0] color_q, color_d, wdata_q, wdata_d;
  logic [1:0] gnt;
  assign arb_en = (state_q == S_IDLE) && !clear_start_in && !pend_q;
  assign last_px = idx_q == PIX_W'(NUM_PIXELS - 1);
  fb_rr_arbiter u_arb (
    .clk(clk_in),
    .rst(rst_in),
    .en (arb_en),
    .req({blt_valid_in, cpu_valid_in}),
    .gnt(gnt)
  );
  assign cpu_ready_out       = gnt[0];
  assign blt_ready_out       = gnt[1];
  assign clear_busy_out      = state_q == S_CLEAR;
  assign swap_pending_out    = pend_q;
  assign swap_done_out       = swap_q;
  assign fb_swap_buffer_out  = swap_q;
  assign fb_write_enable_out = we_q;
  assign fb_write_data_out   = wdata_q;
  assign fb_write_addr_out   = (2 * PIX_W)'({waddr_q, 1'b0});
  // clear beats swap beats grants; swap waits for a frame boundary seen while already waiting
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | swap_req_in;
    idx_d   = idx_q;
    color_d = color_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    swap_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_start_in) begin
          state_d = S_CLEAR;
          color_d = clear_color_in;
          idx_d   = '0;
        end else if (pend_q) begin
          state_d = S_SWAP_WAIT;
        end else if (|gnt) begin
          we_d    = 1'b1;
          waddr_d = gnt[0] ? cpu_addr_in : blt_addr_in;
          wdata_d = gnt[0] ? cpu_data_in : blt_data_in;
        end
      end
      S_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = idx_q;
        wdata_d = color_q;
        state_d = last_px ? S_IDLE : S_CLEAR;
        idx_d   = last_px ? '0 : idx_q + 1'b1;
      end
      S_SWAP_WAIT: begin
        if (frame_start_in) begin
          swap_d  = 1'b1;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  // state and registered write/swap outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      color_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      color_q <= color_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      swap_q  <= swap_d;
    end
  end
`ifdef FB_SCHED_STATS_EN
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  // counts visible writes, saturating, zeroed in the swap pulse cycle
  always_comb cnt_d = swap_d ? '0 : (we_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  // write counter register
  always_ff @(posedge clk_in) begin
    if (rst_in) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign write_count_out = cnt_q;
`else
  assign write_count_out = '0;
`endif
endmodule
